// File: rtl/stream_arb_pkg.sv
// Shared types and constants for the two-input packet arbiter.
// Select polarity: 1 picks source A, 0 picks source B.
package stream_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

endpackage

// File: rtl/rr_grant2.sv
// Two-way round-robin grant with packet lock.
// grant_vld is low only when idle with no source requesting.
module rr_grant2
    import stream_arb_pkg::*;
(
    input  state_t state,
    input  logic   a_valid,
    input  logic   b_valid,
    input  logic   ptr_a,
    input  logic   last_sel,
    output logic   grant,
    output logic   grant_vld
);

    always_comb begin
        grant     = last_sel;
        grant_vld = 1'b0;
        unique case (state)
            LOCK_A: begin
                grant     = SEL_A;
                grant_vld = 1'b1;
            end
            LOCK_B: begin
                grant     = SEL_B;
                grant_vld = 1'b1;
            end
            default: begin
                if (a_valid && b_valid) begin
                    grant     = ptr_a ? SEL_A : SEL_B;
                    grant_vld = 1'b1;
                end else if (a_valid) begin
                    grant     = SEL_A;
                    grant_vld = 1'b1;
                end else if (b_valid) begin
                    grant     = SEL_B;
                    grant_vld = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/stream_arb2_mux.sv
// Packet-aware 2:1 round-robin stream arbiter with a one-entry
// registered output stage.
module stream_arb2_mux
    import stream_arb_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter bit A_FIRST = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              a_valid_i,
    input  logic [DATA_W-1:0] a_data_i,
    input  logic              a_last_i,
    output logic              a_ready_o,
    input  logic              b_valid_i,
    input  logic [DATA_W-1:0] b_data_i,
    input  logic              b_last_i,
    output logic              b_ready_o,
    output logic              sel_o,
    output logic              y_valid_o,
    output logic [DATA_W-1:0] y_data_o,
    output logic              y_last_o,
    output logic              y_src_o,
    input  logic              y_ready_i
);

    state_t state_q, state_d;
    logic   ptr_a_q;
    logic   last_sel_q;
    logic   grant;
    logic   grant_vld;
    logic   can_load;
    logic   acc;
    logic   acc_last;
    logic [DATA_W-1:0] mux_data;

    rr_grant2 u_grant (
        .state     (state_q),
        .a_valid   (a_valid_i),
        .b_valid   (b_valid_i),
        .ptr_a     (ptr_a_q),
        .last_sel  (last_sel_q),
        .grant     (grant),
        .grant_vld (grant_vld)
    );

    assign can_load  = !y_valid_o || y_ready_i;
    assign a_ready_o = can_load && grant_vld && (grant == SEL_A);
    assign b_ready_o = can_load && grant_vld && (grant == SEL_B);
    assign sel_o     = grant;

    assign acc      = (a_valid_i && a_ready_o) || (b_valid_i && b_ready_o);
    assign acc_last = (grant == SEL_A) ? a_last_i : b_last_i;
    assign mux_data = (grant == SEL_A) ? a_data_i : b_data_i;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOCK_A: if (acc && acc_last) state_d = IDLE;
            LOCK_B: if (acc && acc_last) state_d = IDLE;
            default: begin
                if (acc && !acc_last) begin
                    state_d = (grant == SEL_A) ? LOCK_A : LOCK_B;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ptr_a_q    <= A_FIRST;
            last_sel_q <= A_FIRST ? SEL_A : SEL_B;
        end else begin
            state_q <= state_d;
            if (grant_vld) last_sel_q <= grant;
            // Pointer flips away from the winner so packets alternate.
            if (acc && acc_last) ptr_a_q <= (grant == SEL_B);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            y_valid_o <= 1'b0;
            y_data_o  <= '0;
            y_last_o  <= 1'b0;
            y_src_o   <= 1'b0;
        end else if (can_load) begin
            y_valid_o <= acc;
            if (acc) begin
                y_data_o <= mux_data;
                y_last_o <= acc_last;
                y_src_o  <= grant;
            end
        end
    end

endmodule

// File: tb/tb_stream_arb2_mux.sv
// Scoreboard bench for stream_arb2_mux: directed beats per source,
// expected outputs queued and checked by an independent monitor.
module tb_stream_arb2_mux;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         a_valid = 1'b0, b_valid = 1'b0;
    logic [W-1:0] a_data = '0, b_data = '0;
    logic         a_last = 1'b0, b_last = 1'b0;
    logic         a_ready, b_ready, sel;
    logic         y_valid, y_last, y_src;
    logic [W-1:0] y_data;
    logic         y_ready = 1'b1;

    int n_chk = 0;
    int n_fail = 0;

    logic [W:0]   a_q[$];
    logic [W:0]   b_q[$];
    logic [W+1:0] exp_q[$];

    stream_arb2_mux #(.DATA_W(W), .A_FIRST(1'b1)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .a_valid_i (a_valid),
        .a_data_i  (a_data),
        .a_last_i  (a_last),
        .a_ready_o (a_ready),
        .b_valid_i (b_valid),
        .b_data_i  (b_data),
        .b_last_i  (b_last),
        .b_ready_o (b_ready),
        .sel_o     (sel),
        .y_valid_o (y_valid),
        .y_data_o  (y_data),
        .y_last_o  (y_last),
        .y_src_o   (y_src),
        .y_ready_i (y_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin : drv_a
        logic acc;
        forever begin
            @(negedge clk);
            acc = a_valid && a_ready;
            @(posedge clk);
            #1;
            if (acc && a_q.size() > 0) void'(a_q.pop_front());
            if (a_q.size() > 0) begin
                a_valid = 1'b1;
                {a_last, a_data} = a_q[0];
            end else begin
                a_valid = 1'b0;
            end
        end
    end

    initial begin : drv_b
        logic acc;
        forever begin
            @(negedge clk);
            acc = b_valid && b_ready;
            @(posedge clk);
            #1;
            if (acc && b_q.size() > 0) void'(b_q.pop_front());
            if (b_q.size() > 0) begin
                b_valid = 1'b1;
                {b_last, b_data} = b_q[0];
            end else begin
                b_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("one_ready", 32'(a_ready && b_ready), 32'd0);
            if (y_valid && y_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h expected none",
                             {y_src, y_last, y_data});
                end else begin
                    chk("y_beat", 32'({y_src, y_last, y_data}),
                        32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic drain(output int cycles);
        cycles = 0;
        while (cycles < 200 &&
               (exp_q.size() > 0 || a_q.size() > 0 || b_q.size() > 0)) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        chk("drain_done", 32'(exp_q.size() + a_q.size() + b_q.size()), 32'd0);
    endtask

    task automatic wait_y_valid();
        int k = 0;
        while (!y_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("y_valid_seen", 32'(y_valid), 32'd1);
    endtask

    initial begin : stim
        int cyc;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        chk("rst_y_data", 32'(y_data), 32'd0);
        chk("rst_y_last", 32'(y_last), 32'd0);
        chk("rst_y_src", 32'(y_src), 32'd0);
        chk("rst_sel", 32'(sel), 32'd1);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);

        // async reset drops a held beat without a clock edge
        @(posedge clk);
        #1 y_ready = 1'b0;
        #1 a_q.push_back({1'b1, 8'h77});
        wait_y_valid();
        #2 rst = 1'b1;
        #1 chk("async_rst_y_valid", 32'(y_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        y_ready = 1'b1;

        // ties alternate, A first after reset
        @(posedge clk);
        #2;
        a_q.push_back({1'b1, 8'h11});
        a_q.push_back({1'b1, 8'h13});
        b_q.push_back({1'b1, 8'h22});
        b_q.push_back({1'b1, 8'h24});
        exp_q.push_back({1'b1, 1'b1, 8'h11});
        exp_q.push_back({1'b0, 1'b1, 8'h22});
        exp_q.push_back({1'b1, 1'b1, 8'h13});
        exp_q.push_back({1'b0, 1'b1, 8'h24});
        drain(cyc);
        chk("contention_rate", 32'(cyc <= 6), 32'd1);

        // single A beat with B idle
        @(posedge clk);
        #2;
        a_q.push_back({1'b1, 8'h5A});
        exp_q.push_back({1'b1, 1'b1, 8'h5A});
        drain(cyc);

        // A packet locks out a waiting B
        @(posedge clk);
        #2;
        a_q.push_back({1'b0, 8'h01});
        a_q.push_back({1'b0, 8'h02});
        a_q.push_back({1'b1, 8'h03});
        exp_q.push_back({1'b1, 1'b0, 8'h01});
        exp_q.push_back({1'b1, 1'b0, 8'h02});
        exp_q.push_back({1'b1, 1'b1, 8'h03});
        exp_q.push_back({1'b0, 1'b1, 8'hFF});
        @(posedge clk);
        #2 b_q.push_back({1'b1, 8'hFF});
        @(negedge clk);
        chk("lock_b_ready0", 32'(b_ready), 32'd0);
        @(negedge clk);
        chk("lock_b_ready1", 32'(b_ready), 32'd0);
        drain(cyc);

        // backpressure holds the output and both readies
        @(posedge clk);
        #1 y_ready = 1'b0;
        #1;
        a_q.push_back({1'b1, 8'h33});
        b_q.push_back({1'b1, 8'h44});
        exp_q.push_back({1'b1, 1'b1, 8'h33});
        exp_q.push_back({1'b0, 1'b1, 8'h44});
        wait_y_valid();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_y_data", 32'(y_data), 32'h33);
            chk("bp_readies", 32'({a_ready, b_ready}), 32'd0);
        end
        @(posedge clk);
        #1 y_ready = 1'b1;
        drain(cyc);

        // reset while locked on A, then B goes through
        @(posedge clk);
        #2;
        a_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b1, 1'b0, 8'h01});
        drain(cyc);
        b_q.push_back({1'b1, 8'hB1});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rlock_b_ready", 32'(b_ready), 32'd0);
            chk("rlock_a_ready", 32'(a_ready), 32'd1);
        end
        #2 rst = 1'b1;
        #1 chk("rlock_y_valid", 32'(y_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.push_back({1'b0, 1'b1, 8'hB1});
        drain(cyc);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
